// File: rtl/decode_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | decode_pkg                                                         |
// | Opcode/func/ALU encodings and the decoded-control struct.          |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package decode_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLTU = 6'b101011;
    localparam logic [5:0] FN_SLLV = 6'b000100;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_XOR  = 3'b010;
    localparam logic [2:0] ALU_NOR  = 3'b011;
    localparam logic [2:0] ALU_ADD  = 3'b100;
    localparam logic [2:0] ALU_SUB  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;
    localparam logic [2:0] ALU_SLLV = 3'b111;

    typedef struct packed {
        logic [2:0] alu_op;
        logic       write_reg;
        logic [4:0] waddr;
        logic       use_imm;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       illegal;
    } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/decode_logic.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | decode_logic                                                       |
// | Combinational instruction word -> control struct and imm_ext.      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module decode_logic
    import decode_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter bit EN_SLLV = 1'b1
) (
    input  logic [31:0]       instr,
    output ctrl_t             ctrl,
    output logic [DATA_W-1:0] imm_ext
);

    logic [5:0]        w_op;
    logic [5:0]        w_func;
    logic [DATA_W-1:0] w_simm;
    logic [DATA_W-1:0] w_zimm;
    logic              w_zext;
    logic              w_ill;
    logic              w_unused_shamt;

    assign w_op           = instr[31:26];
    assign w_func         = instr[5:0];
    assign w_unused_shamt = ^instr[10:6];

    if (DATA_W > 16) begin : g_ext_wide
        assign w_simm = {{(DATA_W-16){instr[15]}}, instr[15:0]};
        assign w_zimm = {{(DATA_W-16){1'b0}}, instr[15:0]};
    end else begin : g_ext_narrow
        assign w_simm = instr[15:0];
        assign w_zimm = instr[15:0];
    end

    always_comb begin
        ctrl   = '0;
        w_zext = 1'b0;
        w_ill  = 1'b0;
        case (w_op)
            OP_RTYPE: begin
                ctrl.write_reg = 1'b1;
                ctrl.waddr     = instr[15:11];
                case (w_func)
                    FN_ADD:  ctrl.alu_op = ALU_ADD;
                    FN_SUB:  ctrl.alu_op = ALU_SUB;
                    FN_AND:  ctrl.alu_op = ALU_AND;
                    FN_OR:   ctrl.alu_op = ALU_OR;
                    FN_XOR:  ctrl.alu_op = ALU_XOR;
                    FN_NOR:  ctrl.alu_op = ALU_NOR;
                    FN_SLTU: ctrl.alu_op = ALU_SLTU;
                    FN_SLLV: begin
                        ctrl.alu_op = ALU_SLLV;
                        w_ill       = !EN_SLLV;
                    end
                    default: w_ill = 1'b1;
                endcase
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_LW: begin
                ctrl.write_reg = 1'b1;
                ctrl.waddr     = instr[20:16];
                ctrl.use_imm   = 1'b1;
                ctrl.mem_read  = (w_op == OP_LW);
                w_zext         = (w_op == OP_ANDI) || (w_op == OP_ORI) || (w_op == OP_XORI);
                case (w_op)
                    OP_ANDI: ctrl.alu_op = ALU_AND;
                    OP_ORI:  ctrl.alu_op = ALU_OR;
                    OP_XORI: ctrl.alu_op = ALU_XOR;
                    default: ctrl.alu_op = ALU_ADD;
                endcase
            end
            OP_SW: begin
                ctrl.alu_op    = ALU_ADD;
                ctrl.waddr     = instr[20:16];
                ctrl.use_imm   = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            OP_BEQ: begin
                ctrl.alu_op = ALU_SUB;
                ctrl.waddr  = instr[20:16];
                ctrl.branch = 1'b1;
            end
            default: w_ill = 1'b1;
        endcase
        // An undecodable word must not leak any partially decoded control.
        if (w_ill) begin
            ctrl         = '0;
            ctrl.illegal = 1'b1;
        end
    end

    assign imm_ext = w_zext ? w_zimm : w_simm;

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | decode_stage                                                       |
// | Registered decode with valid/ready, flush and illegal counter.     |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module decode_stage
    import decode_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 8,
    parameter bit EN_SLLV = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2:0]        alu_op,
    output logic              write_reg,
    output logic [4:0]        waddr,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [DATA_W-1:0] imm_ext,
    output logic              use_imm,
    output logic              mem_read,
    output logic              mem_write,
    output logic              branch,
    output logic              illegal,
    output logic [CNT_W-1:0]  illegal_cnt
);

    ctrl_t             w_ctrl;
    logic [DATA_W-1:0] w_imm;
    logic              w_accept;

    ctrl_t             r_ctrl;
    logic              r_valid;
    logic [4:0]        r_rs;
    logic [4:0]        r_rt;
    logic [DATA_W-1:0] r_imm;
    logic [CNT_W-1:0]  r_cnt;

    decode_logic #(
        .DATA_W  (DATA_W),
        .EN_SLLV (EN_SLLV)
    ) u_decode_logic (
        .instr   (instr),
        .ctrl    (w_ctrl),
        .imm_ext (w_imm)
    );

    // flush is folded into in_ready so it also blocks acceptance.
    assign in_ready = !flush && (!r_valid || out_ready);
    assign w_accept = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_ctrl  <= '0;
            r_rs    <= '0;
            r_rt    <= '0;
            r_imm   <= '0;
            r_cnt   <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_ctrl  <= w_ctrl;
            r_rs    <= instr[25:21];
            r_rt    <= instr[20:16];
            r_imm   <= w_imm;
            if (w_ctrl.illegal && (r_cnt != {CNT_W{1'b1}})) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_valid   = r_valid;
    assign alu_op      = r_ctrl.alu_op;
    assign write_reg   = r_ctrl.write_reg;
    assign waddr       = r_ctrl.waddr;
    assign rs          = r_rs;
    assign rt          = r_rt;
    assign imm_ext     = r_imm;
    assign use_imm     = r_ctrl.use_imm;
    assign mem_read    = r_ctrl.mem_read;
    assign mem_write   = r_ctrl.mem_write;
    assign branch      = r_ctrl.branch;
    assign illegal     = r_ctrl.illegal;
    assign illegal_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_decode_stage                                                    |
// | Scoreboard bench: default build (A) and DATA_W=16/CNT_W=2/no-sllv  |
// | build (B) driven in lockstep. Revision: 1.0                        |
// +--------------------------------------------------------------------+
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] instr;

    logic        in_ready_a, out_valid_a, write_reg_a, use_imm_a, mem_read_a, mem_write_a, branch_a, illegal_a;
    logic [2:0]  alu_op_a;
    logic [4:0]  waddr_a, rs_a, rt_a;
    logic [31:0] imm_a;
    logic [7:0]  cnt_a;

    logic        in_ready_b, out_valid_b, write_reg_b, use_imm_b, mem_read_b, mem_write_b, branch_b, illegal_b;
    logic [2:0]  alu_op_b;
    logic [4:0]  waddr_b, rs_b, rt_b;
    logic [15:0] imm_b;
    logic [1:0]  cnt_b;

    always #5 clk = ~clk;

    decode_stage u_dut_a (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
        .instr(instr), .out_valid(out_valid_a), .out_ready(out_ready), .alu_op(alu_op_a),
        .write_reg(write_reg_a), .waddr(waddr_a), .rs(rs_a), .rt(rt_a), .imm_ext(imm_a),
        .use_imm(use_imm_a), .mem_read(mem_read_a), .mem_write(mem_write_a), .branch(branch_a),
        .illegal(illegal_a), .illegal_cnt(cnt_a)
    );

    decode_stage #(.DATA_W(16), .CNT_W(2), .EN_SLLV(1'b0)) u_dut_b (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
        .instr(instr), .out_valid(out_valid_b), .out_ready(out_ready), .alu_op(alu_op_b),
        .write_reg(write_reg_b), .waddr(waddr_b), .rs(rs_b), .rt(rt_b), .imm_ext(imm_b),
        .use_imm(use_imm_b), .mem_read(mem_read_b), .mem_write(mem_write_b), .branch(branch_b),
        .illegal(illegal_b), .illegal_cnt(cnt_b)
    );

    typedef struct packed {
        logic [2:0]  alu;
        logic        wr;
        logic [4:0]  waddr;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] imm;
        logic        ui;
        logic        mr;
        logic        mw;
        logic        br;
        logic        ill;
        logic [7:0]  cnt;
    } exp_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [2:0]  alu;
        logic        wr;
        logic [4:0]  waddr;
        logic        ui;
        logic        mr;
        logic        mw;
        logic        br;
        logic        ill;
        logic        b_ill;
        logic [31:0] imm;
    } vec_t;

    vec_t vt [18];
    exp_t qa [$];
    exp_t qb [$];
    exp_t mon_e, mon_a, prev_a, prev_b;
    bit   hold_a = 1'b0;
    bit   hold_b = 1'b0;
    bit   exp_valid = 1'b0;
    int   ecnt_a = 0;
    int   ecnt_b = 0;
    int   total = 0;
    int   bad = 0;

    function automatic exp_t pack_a();
        exp_t p;
        p = '{alu_op_a, write_reg_a, waddr_a, rs_a, rt_a, imm_a, use_imm_a,
              mem_read_a, mem_write_a, branch_a, illegal_a, cnt_a};
        return p;
    endfunction

    function automatic exp_t pack_b();
        exp_t p;
        p = '{alu_op_b, write_reg_b, waddr_b, rs_b, rt_b, {16'h0, imm_b}, use_imm_b,
              mem_read_b, mem_write_b, branch_b, illegal_b, {6'h0, cnt_b}};
        return p;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic sv(input int i, input logic [31:0] ins, input logic [2:0] alu, input bit wr,
                      input logic [4:0] wa, input bit ui, input bit mr, input bit mw, input bit br,
                      input bit ill, input bit bill, input logic [31:0] imm);
        vt[i] = '{ins, alu, wr, wa, ui, mr, mw, br, ill, bill, imm};
    endtask

    // Monitor: pops and compares on every transfer, checks stability while stalled.
    always @(negedge clk) begin
        if (!rst && !flush && out_ready) begin
            if (out_valid_a) begin
                if (qa.size() == 0) begin
                    total++; bad++;
                    $display("FAIL xfer_a: actual=unexpected output required=none");
                end else begin
                    mon_e = qa.pop_front();
                    mon_a = pack_a();
                    if (mon_e.ill) mon_a.waddr = mon_e.waddr;
                    chk("xfer_a", mon_a, mon_e);
                end
            end
            if (out_valid_b) begin
                if (qb.size() == 0) begin
                    total++; bad++;
                    $display("FAIL xfer_b: actual=unexpected output required=none");
                end else begin
                    mon_e = qb.pop_front();
                    mon_a = pack_b();
                    if (mon_e.ill) mon_a.waddr = mon_e.waddr;
                    chk("xfer_b", mon_a, mon_e);
                end
            end
        end
        if (!rst && !flush && !out_ready && out_valid_a) begin
            if (hold_a) chk("stall_a", pack_a(), prev_a);
            prev_a = pack_a();
            hold_a = 1'b1;
        end else begin
            hold_a = 1'b0;
        end
        if (!rst && !flush && !out_ready && out_valid_b) begin
            if (hold_b) chk("stall_b", pack_b(), prev_b);
            prev_b = pack_b();
            hold_b = 1'b1;
        end else begin
            hold_b = 1'b0;
        end
    end

    // One clock of stimulus; the expected handshake state is tracked by the bench.
    task automatic cyc(input bit r, input bit fl, input bit iv, input int vi, input bit ordy, output bit acc);
        exp_t ea, eb;
        vec_t v;
        bit   rdy;
        v         = vt[vi];
        rst       = r;
        flush     = fl;
        in_valid  = iv;
        instr     = v.instr;
        out_ready = ordy;
        rdy       = !fl && (!exp_valid || ordy);
        acc       = iv && rdy && !r;
        @(negedge clk);
        if (!r) begin
            chk("in_ready_a", {63'h0, in_ready_a}, {63'h0, rdy});
            chk("in_ready_b", {63'h0, in_ready_b}, {63'h0, rdy});
        end
        chk("out_valid_a", {63'h0, out_valid_a}, {63'h0, exp_valid});
        chk("out_valid_b", {63'h0, out_valid_b}, {63'h0, exp_valid});
        @(posedge clk);
        if (r) begin
            exp_valid = 1'b0;
            ecnt_a    = 0;
            ecnt_b    = 0;
            qa.delete();
            qb.delete();
        end else if (fl) begin
            exp_valid = 1'b0;
            qa.delete();
            qb.delete();
        end else if (acc) begin
            ea = '{v.alu, v.wr, v.waddr, v.instr[25:21], v.instr[20:16], v.imm,
                   v.ui, v.mr, v.mw, v.br, v.ill, 8'h0};
            if (v.ill && ecnt_a < 255) ecnt_a++;
            ea.cnt = ecnt_a[7:0];
            eb     = ea;
            eb.imm = {16'h0, v.imm[15:0]};
            if (v.b_ill) begin
                eb.alu = 3'b000; eb.wr = 1'b0; eb.ui = 1'b0; eb.mr = 1'b0;
                eb.mw  = 1'b0;   eb.br = 1'b0; eb.ill = 1'b1;
            end
            if (eb.ill && ecnt_b < 3) ecnt_b++;
            eb.cnt = ecnt_b[7:0];
            qa.push_back(ea);
            qb.push_back(eb);
            exp_valid = 1'b1;
        end else if (ordy) begin
            exp_valid = 1'b0;
        end
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int k;
        int bp [3] = '{8, 12, 14};
        int il [5] = '{16, 17, 16, 7, 16};

        sv(0,  32'h00851020, 3'b100, 1, 2, 0, 0, 0, 0, 0, 0, 32'h00001020);
        sv(1,  32'h00851022, 3'b101, 1, 2, 0, 0, 0, 0, 0, 0, 32'h00001022);
        sv(2,  32'h00851024, 3'b000, 1, 2, 0, 0, 0, 0, 0, 0, 32'h00001024);
        sv(3,  32'h00851025, 3'b001, 1, 2, 0, 0, 0, 0, 0, 0, 32'h00001025);
        sv(4,  32'h00851026, 3'b010, 1, 2, 0, 0, 0, 0, 0, 0, 32'h00001026);
        sv(5,  32'h00851027, 3'b011, 1, 2, 0, 0, 0, 0, 0, 0, 32'h00001027);
        sv(6,  32'h0085102B, 3'b110, 1, 2, 0, 0, 0, 0, 0, 0, 32'h0000102B);
        sv(7,  32'h00851004, 3'b111, 1, 2, 0, 0, 0, 0, 0, 1, 32'h00001004);
        sv(8,  32'h2082FFFF, 3'b100, 1, 2, 1, 0, 0, 0, 0, 0, 32'hFFFFFFFF);
        sv(9,  32'h3482FFFF, 3'b001, 1, 2, 1, 0, 0, 0, 0, 0, 32'h0000FFFF);
        sv(10, 32'h30828001, 3'b000, 1, 2, 1, 0, 0, 0, 0, 0, 32'h00008001);
        sv(11, 32'h38827FFF, 3'b010, 1, 2, 1, 0, 0, 0, 0, 0, 32'h00007FFF);
        sv(12, 32'h8C820004, 3'b100, 1, 2, 1, 1, 0, 0, 0, 0, 32'h00000004);
        sv(13, 32'hAC820004, 3'b100, 0, 2, 1, 0, 1, 0, 0, 0, 32'h00000004);
        sv(14, 32'h10850003, 3'b101, 0, 5, 0, 0, 0, 1, 0, 0, 32'h00000003);
        sv(15, 32'h1085FFFE, 3'b101, 0, 5, 0, 0, 0, 1, 0, 0, 32'hFFFFFFFE);
        sv(16, 32'hFC851020, 3'b000, 0, 0, 0, 0, 0, 0, 1, 1, 32'h00001020);
        sv(17, 32'h00851021, 3'b000, 0, 0, 0, 0, 0, 0, 1, 1, 32'h00001021);

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; instr = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_a", pack_a(), 64'h0);
        chk("reset_b", pack_b(), 64'h0);
        chk("reset_valid", {62'h0, out_valid_a, out_valid_b}, 64'h0);
        chk("reset_ready", {62'h0, in_ready_a, in_ready_b}, 64'h3);

        // Back-to-back sweep of every legal encoding.
        for (int i = 0; i < 16; i++) cyc(0, 0, 1, i, 1, acc);
        cyc(0, 0, 0, 0, 1, acc);

        // Backpressure: out_ready low for two cycles mid-stream.
        k = 0;
        for (int c = 0; c < 8; c++) begin
            cyc(0, 0, (k < 3), bp[(k < 3) ? k : 0], !(c == 2 || c == 3), acc);
            if (acc) k++;
        end
        chk("bp_accepted", 64'(k), 64'd3);

        // Flush with a held illegal output and a new valid word.
        cyc(0, 0, 1, 16, 0, acc);
        cyc(0, 1, 1, 17, 1, acc);
        chk("flush_cnt_a", {56'h0, cnt_a}, 64'd1);
        chk("flush_cnt_b", {62'h0, cnt_b}, 64'd2);
        cyc(0, 0, 0, 0, 1, acc);

        // Reset while an output is held under backpressure.
        cyc(0, 0, 1, 12, 0, acc);
        cyc(0, 0, 1, 13, 0, acc);
        cyc(1, 0, 0, 0, 0, acc);
        chk("midrst_a", pack_a(), 64'h0);
        chk("midrst_b", pack_b(), 64'h0);
        cyc(0, 0, 0, 0, 1, acc);

        // Illegal stream: B counter saturates at 3 (1,2,3,3,3).
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, il[i], 1, acc);
        cyc(0, 0, 0, 0, 1, acc);
        chk("sat_cnt_b", {62'h0, cnt_b}, 64'd3);
        chk("cnt_a", {56'h0, cnt_a}, 64'd4);
        chk("drained", 64'(qa.size() + qb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
